dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache with its miss-handling FSM, placed between the MEM stage and main memory. It generates the `DCacheMiss` stall request consumed by the pipeline hazard logic. It also owns the word-serial refill/write-back handshake toward memory. The pipeline stalls and holds the request while `miss` is high, then completes the access as a hit.

## Interface
Parameters:
- `SET_LOG`, 4: log2 number of sets (16 sets).
- `LINE_WORDS_LOG`, 3: log2 32-bit words per line (8 words).
- Derived: word offset `addr[LINE_WORDS_LOG+1:2]`, index next `SET_LOG` bits, tag = remaining upper bits (23 bits at defaults).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `rd_req`  in  1  load in MEM stage.
- `wr_req`  in  1  store in MEM stage; never asserted together with `rd_req`.
- `addr`  in  32  byte address, word aligned.
- `wr_data`  in  32  store data, already lane-aligned.
- `wr_be`  in  4  byte enables for store.
- `rd_data`  out  32  load data; valid when `rd_req && !miss`.
- `miss`  out  1  stall request to the hazard unit (`DCacheMiss`).
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  1 = write word, 0 = read word.
- `mem_addr`  out  32  word address of the current transaction.
- `mem_wdata`  out  32  write-back data.
- `mem_rdata`  in  32  refill data; valid with `mem_ack`.
- `mem_ack`  in  1  completes one word transaction.

## Operation
- Per set: valid bit, dirty bit, tag, and data line.
- Hit = valid && tag match. On a hit, `rd_data` is combinational from the array. A store hit writes the enabled bytes at the clock edge and sets dirty.
- FSM states:
  - IDLE → WB, on a request miss with a dirty victim.
  - IDLE → REFILL, on a request miss with a clean or invalid victim.
  - WB → REFILL, after ack of word `2^LINE_WORDS_LOG−1`.
  - REFILL → IDLE, after the last ack. At that edge the line is written, valid=1, dirty=0, and the tag is updated.
- `miss` = (state≠IDLE) || ((rd_req||wr_req) && !hit). It is combinational and drops in the first IDLE cycle where the held request hits.
- Write miss uses the same path: refill first, then the store completes as a hit.
- Word counter `cnt` (`LINE_WORDS_LOG` bits):
  - Cleared on each IDLE→WB and IDLE→REFILL transition and on WB→REFILL.
  - Increments on each `mem_ack`.
  - The last word is cnt = all-ones.
- Addressing:
  - WB: `mem_addr` = {victim tag, index, cnt, 2'b00}, `mem_we`=1, `mem_wdata` = victim word[cnt].
  - REFILL: `mem_addr` = {req tag, index, cnt, 2'b00}, `mem_we`=0. Refill words are captured into a line buffer or directly into the array.
- The victim tag is captured at the IDLE→WB edge. The requester holds `addr` stable while `miss`=1, so the index is taken from `addr`.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, cnt=0, all valid and dirty bits = 0. Data array is not cleared.
- While `rst_n`=0, combinational outputs are forced to: `miss`=0, `mem_req`=0, `mem_we`=0, `rd_data`=0.
- Reset mid-WB or mid-REFILL: the transaction is abandoned at that edge, `mem_req` drops, and no line is marked valid.
- Memory handshake:
  - `mem_req`=1 exactly in WB and REFILL.
  - `mem_addr`, `mem_we`, and `mem_wdata` are stable until `mem_ack` is sampled.
  - Back-to-back words are allowed; `mem_ack` may be high on consecutive cycles.
  - `mem_ack` outside WB or REFILL is ignored.
- Hit latency: 0 cycles (`miss`=0 in the request cycle).
- Clean miss: `miss` is high for 1 + Σ(cycles to each of 8 acks) cycles. With a zero-wait memory (ack every cycle) that is 9 cycles, and the access hits in cycle 10.
- Dirty miss: add 8 ack-cycles for WB. With zero-wait memory `miss` is high for 17 cycles.
- No request in a cycle: no state change. A request that drops while the FSM is busy does not abort the FSM.

## Structure
- Package `dcache_pkg` contains:
  - State enum (IDLE, WB, REFILL).
  - Default `SET_LOG` and `LINE_WORDS_LOG`.
  - Address-slicing helper functions and tag-width constant.
- One sub-module, `dcache_data_ram`:
  - Sets × words × 32 bits, with async read.
  - Synchronous write with 4-bit byte enable on one word port.
  - Also takes the full-line refill writes.
- Tags and valid/dirty bits live as flops in `dcache_ctrl`.

## Test plan
- **Cold read:** after reset, `rd_req` to `addr`=0x0000_0104 with zero-wait memory.
  - Expect `miss`=1 for 9 cycles.
  - Expect reads of 0x100..0x11C in order, then `rd_data` = mem[0x104] with `miss`=0.
- **Store hit then dirty eviction:**
  - Store `wr_be`=4'b0011, data 0xAAAA_BBBB to 0x104 → hit; word low half becomes 0xBBBB.
  - Then read 0x304 (same index 8) → 8 writes to 0x100..0x11C with the modified word at 0x104, then 8 reads from 0x300..0x31C, `miss` high 17 cycles.
- **Write miss allocate:** store to 0x208 into an empty set → refill of 0x200..0x21C, then the store commits. Subsequent read of 0x208 hits with the new data.
- **Slow memory:** `mem_ack` every 3rd cycle during refill. `mem_addr`/`mem_we` stay stable between acks, and `miss` lasts 1+24 cycles.
- **Reset mid-refill:** `rst_n`=0 after 4 acks → next cycle `mem_req`=0 and state IDLE. A re-issued read of the same address misses again and does a full 8-word refill.
- **Read hit with back-to-back mixed requests:** read, store, read to the same line → `miss` stays 0 and the last read returns the stored value.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-slicing helpers for the data cache.
package dcache_pkg;

  localparam int SET_LOG_DEF        = 4;
  localparam int LINE_WORDS_LOG_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } state_t;

  function automatic int tag_width(input int set_log, input int line_words_log);
    return 32 - set_log - line_words_log - 2;
  endfunction

  localparam int TAG_W = tag_width(SET_LOG_DEF, LINE_WORDS_LOG_DEF);

  // Helpers return right-aligned fields; callers size-cast to their own widths.
  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int line_words_log);
    return (a >> 2) & ((32'd1 << line_words_log) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int set_log,
                                             input int line_words_log);
    return (a >> (line_words_log + 2)) & ((32'd1 << set_log) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int set_log,
                                           input int line_words_log);
    return a >> (set_log + line_words_log + 2);
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Cache data array: sets x words x 32 bits, asynchronous read, byte-enabled word write.
module dcache_data_ram #(
  parameter int SET_LOG        = 4,
  parameter int LINE_WORDS_LOG = 3
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [SET_LOG-1:0]        set,
  input  logic [LINE_WORDS_LOG-1:0] word,
  input  logic [3:0]                be,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata
);

  logic [31:0] mem [2**SET_LOG][2**LINE_WORDS_LOG];

  // NOTE: the array has no reset; valid bits decide whether its contents mean anything.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[set][word][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[set][word];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache with word-serial miss handling.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int SET_LOG        = SET_LOG_DEF,
  parameter int LINE_WORDS_LOG = LINE_WORDS_LOG_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int SETS = 1 << SET_LOG;
  localparam int TW   = tag_width(SET_LOG, LINE_WORDS_LOG);

  state_t                    state_q, state_d;
  logic [LINE_WORDS_LOG-1:0] cnt_q, cnt_d;
  logic [SETS-1:0]           valid_q, dirty_q;
  logic [TW-1:0]             tag_q [SETS];
  logic [TW-1:0]             wb_tag_q;

  logic [SET_LOG-1:0]        idx;
  logic [LINE_WORDS_LOG-1:0] off;
  logic [TW-1:0]             req_tag;
  logic                      req, hit, victim_dirty, last;

  logic                      ram_we;
  logic [LINE_WORDS_LOG-1:0] ram_word;
  logic [3:0]                ram_be;
  logic [31:0]               ram_wdata, ram_rdata;

  assign idx          = SET_LOG'(addr_index(addr, SET_LOG, LINE_WORDS_LOG));
  assign off          = LINE_WORDS_LOG'(addr_offset(addr, LINE_WORDS_LOG));
  assign req_tag      = TW'(addr_tag(addr, SET_LOG, LINE_WORDS_LOG));
  assign req          = rd_req || wr_req;
  assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];
  assign last         = &cnt_q;
  assign mem_wdata    = ram_rdata;

  dcache_data_ram #(
    .SET_LOG        (SET_LOG),
    .LINE_WORDS_LOG (LINE_WORDS_LOG)
  ) u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .set   (idx),
    .word  (ram_word),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    miss      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    rd_data   = '0;
    ram_we    = 1'b0;
    ram_word  = off;
    ram_be    = wr_be;
    ram_wdata = wr_data;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          miss    = 1'b1;
          cnt_d   = '0;
          state_d = victim_dirty ? WB : REFILL;
        end else if (hit) begin
          ram_we  = wr_req;
          rd_data = rd_req ? ram_rdata : '0;
        end
      end
      WB: begin
        miss     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {wb_tag_q, idx, cnt_q, 2'b00};
        ram_word = cnt_q;
        if (mem_ack) begin
          cnt_d = last ? '0 : cnt_q + 1'b1;
          if (last) state_d = REFILL;
        end
      end
      REFILL: begin
        miss      = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {req_tag, idx, cnt_q, 2'b00};
        ram_word  = cnt_q;
        ram_be    = 4'hF;
        ram_wdata = mem_rdata;
        if (mem_ack) begin
          ram_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset holds the pipeline and memory side quiet and blocks array writes.
    if (!rst_n) begin
      miss    = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      rd_data = '0;
      ram_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && wr_req && hit) dirty_q[idx] <= 1'b1;
      if (state_q == REFILL && mem_ack && last) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tags are only meaningful under a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == IDLE && req && !hit && victim_dirty) wb_tag_q <= tag_q[idx];
      if (state_q == REFILL && mem_ack && last) tag_q[idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl against a zero/slow-wait memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, wr_req;
  logic [31:0] addr, wr_data;
  logic [3:0]  wr_be;
  logic [31:0] rd_data;
  logic        miss, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int n_assert = 0;
  int n_fail   = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .addr      (addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_data   (rd_data),
    .miss      (miss),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // Main-memory image: each word holds its own low address half under a fixed marker.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // First miss cycle: still IDLE, so miss is up but memory is not yet requested.
  task automatic start_miss();
    @(negedge clk);
    check("miss_first", 32'(miss), 32'd1);
    check("req_first", 32'(mem_req), 32'd0);
    miss_cnt = 1;
    cyc();
  endtask

  // Serves nwords consecutive word transactions, with gap idle cycles before each ack.
  task automatic serve(input logic we, input logic [31:0] base, input int nwords,
                       input int gap, input logic [31:0] mod_addr, input logic [31:0] mod_val);
    logic [31:0] a;
    for (int w = 0; w < nwords; w++) begin
      a = base + 32'(4 * w);
      for (int g = 0; g < gap; g++) begin
        mem_ack = 1'b0;
        @(negedge clk);
        check("gap_addr", mem_addr, a);
        check("gap_we", 32'(mem_we), 32'(we));
        check("gap_miss", 32'(miss), 32'd1);
        miss_cnt++;
        cyc();
      end
      mem_ack   = 1'b1;
      mem_rdata = mem_val(a);
      @(negedge clk);
      check("xfer_req", 32'(mem_req), 32'd1);
      check("xfer_we", 32'(mem_we), 32'(we));
      check("xfer_addr", mem_addr, a);
      if (we) check("wb_data", mem_wdata, (a == mod_addr) ? mod_val : mem_val(a));
      check("xfer_miss", 32'(miss), 32'd1);
      miss_cnt++;
      cyc();
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] exp);
    @(negedge clk);
    check({tag, "_miss"}, 32'(miss), 32'd0);
    check({tag, "_data"}, rd_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; rd_req = 1'b1; wr_req = 1'b0; addr = 32'h104;
    wr_data = '0; wr_be = 4'h0; mem_rdata = '0; mem_ack = 1'b0;

    // Reset: outputs forced low even with a request pending.
    cyc(); cyc();
    @(negedge clk);
    check("rst_miss", 32'(miss), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    cyc();
    rst_n = 1'b1; rd_req = 1'b0;
    @(negedge clk);
    check("idle_miss", 32'(miss), 32'd0);
    check("idle_mem_req", 32'(mem_req), 32'd0);
    cyc();

    // Cold read of 0x104, zero-wait refill.
    rd_req = 1'b1; addr = 32'h104;
    start_miss();
    serve(1'b0, 32'h100, 8, 0, '0, '0);
    expect_hit("cold_rd", 32'hC0DE_0104);
    check("cold_miss_cycles", 32'(miss_cnt), 32'd9);
    cyc();

    // Store hit on the low half of 0x104.
    rd_req = 1'b0; wr_req = 1'b1; wr_data = 32'hAAAA_BBBB; wr_be = 4'b0011;
    @(negedge clk);
    check("st_hit_miss", 32'(miss), 32'd0);
    cyc();
    wr_req = 1'b0; rd_req = 1'b1;
    expect_hit("st_readback", 32'hC0DE_BBBB);
    cyc();

    // Conflicting read of 0x304 evicts the dirty line first.
    addr = 32'h304;
    start_miss();
    serve(1'b1, 32'h100, 8, 0, 32'h104, 32'hC0DE_BBBB);
    serve(1'b0, 32'h300, 8, 0, '0, '0);
    expect_hit("dirty_rd", 32'hC0DE_0304);
    check("dirty_miss_cycles", 32'(miss_cnt), 32'd17);
    cyc();

    // Write miss into empty set 0: allocate, then the store commits.
    rd_req = 1'b0; wr_req = 1'b1; addr = 32'h208; wr_data = 32'h1234_5678; wr_be = 4'hF;
    start_miss();
    serve(1'b0, 32'h200, 8, 0, '0, '0);
    @(negedge clk);
    check("wmiss_commit_miss", 32'(miss), 32'd0);
    check("wmiss_miss_cycles", 32'(miss_cnt), 32'd9);
    cyc();
    wr_req = 1'b0; rd_req = 1'b1;
    expect_hit("wmiss_readback", 32'h1234_5678);
    cyc();

    // Slow memory: ack every third cycle.
    addr = 32'h0A0;
    start_miss();
    serve(1'b0, 32'h0A0, 8, 2, '0, '0);
    expect_hit("slow_rd", 32'hC0DE_00A0);
    check("slow_miss_cycles", 32'(miss_cnt), 32'd25);
    cyc();

    // Reset after four refill acks abandons the line.
    addr = 32'h0C4;
    start_miss();
    serve(1'b0, 32'h0C0, 4, 0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_miss", 32'(miss), 32'd0);
    cyc();
    rst_n = 1'b1;
    start_miss();
    serve(1'b0, 32'h0C0, 8, 0, '0, '0);
    expect_hit("rerd", 32'hC0DE_00C4);
    check("rerd_miss_cycles", 32'(miss_cnt), 32'd9);
    cyc();

    // Back-to-back read / store / read on the same line, with a stray ack in IDLE.
    addr = 32'h0C8; mem_ack = 1'b1;
    expect_hit("b2b_rd1", 32'hC0DE_00C8);
    check("stray_ack_req", 32'(mem_req), 32'd0);
    cyc();
    mem_ack = 1'b0; rd_req = 1'b0; wr_req = 1'b1; wr_data = 32'h5555_6666; wr_be = 4'b1100;
    @(negedge clk);
    check("b2b_st_miss", 32'(miss), 32'd0);
    cyc();
    wr_req = 1'b0; rd_req = 1'b1;
    expect_hit("b2b_rd2", 32'h5555_00C8);
    cyc();
    rd_req = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog: a stuck handshake still ends the run with a reported failure.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
